// File: rtl/vx_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// vx_issue_scoreboard
//
// Issue-stage register scoreboard. Tracks, per warp, which destination
// registers have an instruction in flight. An incoming instruction is
// held upstream while any register it reads, or the register it will write,
// is still in flight. Accepted instructions pass through a single output
// register with a valid/ready handshake. Writeback releases the register.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   in_wis                     warp index of the incoming instruction
//   in_wb, in_rd               destination write flag and register
//   in_rs1..in_rs3, in_used_rs source registers and which of them are read
//   in_data                    opaque payload, passed through
//   out_valid / out_ready      downstream handshake
//   out_wis .. out_data        registered copies of the accepted instruction
//   wb_valid, wb_wis, wb_rd,   writeback release; only the final beat
//   wb_eop                     (wb_eop=1) frees the register
//   perf_stalls                cycles spent stalled on a hazard
//   err_release                sticky: a release hit a register not in use
// ---------------------------------------------------------------------------
module vx_issue_scoreboard #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 64,
    parameter int DATAW     = 128,
    localparam int WIS_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NR_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIS_W-1:0]   in_wis,
    input  logic               in_wb,
    input  logic [NR_BITS-1:0] in_rd,
    input  logic [NR_BITS-1:0] in_rs1,
    input  logic [NR_BITS-1:0] in_rs2,
    input  logic [NR_BITS-1:0] in_rs3,
    input  logic [2:0]         in_used_rs,
    input  logic [DATAW-1:0]   in_data,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIS_W-1:0]   out_wis,
    output logic [NR_BITS-1:0] out_rd,
    output logic [NR_BITS-1:0] out_rs1,
    output logic [NR_BITS-1:0] out_rs2,
    output logic [NR_BITS-1:0] out_rs3,
    output logic               out_wb,
    output logic [DATAW-1:0]   out_data,

    input  logic               wb_valid,
    input  logic [WIS_W-1:0]   wb_wis,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,

    output logic [31:0]        perf_stalls,
    output logic               err_release
);

    // -----------------------------------------------------------------------
    // In-use bitmap, one row per warp
    // -----------------------------------------------------------------------
    logic [NUM_REGS-1:0] w_inuse [NUM_WARPS];

    logic [NUM_REGS-1:0] w_row;
    logic [2:0]          w_rs_busy;
    logic                w_rd_busy;
    logic                w_hazard;
    logic                w_fire;
    logic                w_set;
    logic                w_clr;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    logic                r_out_valid;
    logic [WIS_W-1:0]    r_out_wis;
    logic [NR_BITS-1:0]  r_out_rd;
    logic [NR_BITS-1:0]  r_out_rs1;
    logic [NR_BITS-1:0]  r_out_rs2;
    logic [NR_BITS-1:0]  r_out_rs3;
    logic                r_out_wb;
    logic [DATAW-1:0]    r_out_data;
    logic [31:0]         r_perf_stalls;
    logic                r_err_release;

    // Bit 0 is masked here as well as never being set, so x0 can never stall
    // even if a row were somehow corrupted.
    assign w_row = {w_inuse[in_wis][NUM_REGS-1:1], 1'b0};

    assign w_rs_busy[0] = in_used_rs[0] & w_row[in_rs1];
    assign w_rs_busy[1] = in_used_rs[1] & w_row[in_rs2];
    assign w_rs_busy[2] = in_used_rs[2] & w_row[in_rs3];
    assign w_rd_busy    = in_wb & w_row[in_rd];

    // Hazard looks only at the registered bitmap: a release becomes visible
    // one cycle after writeback, which keeps wb -> in_ready off the
    // critical path.
    assign w_hazard = in_valid & ((|w_rs_busy) | w_rd_busy);

    assign in_ready = ~reset & ~w_hazard & (~r_out_valid | out_ready);
    assign w_fire   = in_valid & in_ready;

    assign w_set = w_fire & in_wb & (in_rd != '0);
    assign w_clr = wb_valid & wb_eop & (wb_rd != '0);

    assign w_set_mask = w_set ? (NUM_REGS'(1) << in_rd) : '0;
    assign w_clr_mask = w_clr ? (NUM_REGS'(1) << wb_rd) : '0;

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [NUM_REGS-1:0] r_row;
            logic                w_set_sel;
            logic                w_clr_sel;

            assign w_set_sel = (in_wis == WIS_W'(gi));
            assign w_clr_sel = (wb_wis == WIS_W'(gi));

            // Clear is applied first so a same-cycle set of the same bit wins.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_row <= '0;
                end else begin
                    r_row <= (r_row & ~(w_clr_sel ? w_clr_mask : '0))
                           | (w_set_sel ? w_set_mask : '0);
                end
            end

            assign w_inuse[gi] = r_row;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_wis   <= '0;
            r_out_rd    <= '0;
            r_out_rs1   <= '0;
            r_out_rs2   <= '0;
            r_out_rs3   <= '0;
            r_out_wb    <= 1'b0;
            r_out_data  <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_wis   <= in_wis;
            r_out_rd    <= in_rd;
            r_out_rs1   <= in_rs1;
            r_out_rs2   <= in_rs2;
            r_out_rs3   <= in_rs3;
            r_out_wb    <= in_wb;
            r_out_data  <= in_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Stall counter and release-error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls <= '0;
            r_err_release <= 1'b0;
        end else begin
            if (w_hazard) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
            // Checked against the registered bitmap, before any same-cycle set.
            if (w_clr && !w_inuse[wb_wis][wb_rd]) begin
                r_err_release <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_wis     = r_out_wis;
    assign out_rd      = r_out_rd;
    assign out_rs1     = r_out_rs1;
    assign out_rs2     = r_out_rs2;
    assign out_rs3     = r_out_rs3;
    assign out_wb      = r_out_wb;
    assign out_data    = r_out_data;
    assign perf_stalls = r_perf_stalls;
    assign err_release = r_err_release;

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_vx_issue_scoreboard
//
// Table of per-cycle vectors with hand-derived expectations for in_ready,
// out_valid, perf_stalls and err_release, followed by a hand-written
// mid-operation reset sequence. Accepted instructions are pushed to a queue
// and compared against the output register when it hands over downstream.
// ---------------------------------------------------------------------------
module tb_vx_issue_scoreboard;

    localparam int NW = 4;
    localparam int NR = 64;
    localparam int DW = 128;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_wis;
    logic          in_wb;
    logic [5:0]    in_rd;
    logic [5:0]    in_rs1;
    logic [5:0]    in_rs2;
    logic [5:0]    in_rs3;
    logic [2:0]    in_used_rs;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_wis;
    logic [5:0]    out_rd;
    logic [5:0]    out_rs1;
    logic [5:0]    out_rs2;
    logic [5:0]    out_rs3;
    logic          out_wb;
    logic [DW-1:0] out_data;
    logic          wb_valid;
    logic [1:0]    wb_wis;
    logic [5:0]    wb_rd;
    logic          wb_eop;
    logic [31:0]   perf_stalls;
    logic          err_release;

    vx_issue_scoreboard #(
        .NUM_WARPS (NW),
        .NUM_REGS  (NR),
        .DATAW     (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wis      (in_wis),
        .in_wb       (in_wb),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rs3      (in_rs3),
        .in_used_rs  (in_used_rs),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wis     (out_wis),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rs3     (out_rs3),
        .out_wb      (out_wb),
        .out_data    (out_data),
        .wb_valid    (wb_valid),
        .wb_wis      (wb_wis),
        .wb_rd       (wb_rd),
        .wb_eop      (wb_eop),
        .perf_stalls (perf_stalls),
        .err_release (err_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    wis;
        logic [5:0]    rd;
        logic [5:0]    rs1;
        logic [5:0]    rs2;
        logic [5:0]    rs3;
        logic          wb;
        logic [DW-1:0] data;
    } pkt_t;

    typedef struct {
        logic       v;
        logic [1:0] wis;
        logic       wb;
        logic [5:0] rd;
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic [5:0] rs3;
        logic [2:0] used;
        logic       ordy;
        logic       wbv;
        logic [1:0] wbw;
        logic [5:0] wbr;
        logic       eop;
        logic       exp_rdy;
        logic       exp_ov;
        int         exp_st;
        logic       exp_err;
    } vec_t;

    int   n_cmp;
    int   n_err;
    pkt_t sb_q[$];
    pkt_t prev_pkt;
    logic prev_hold;
    vec_t vecs[24];

    function automatic vec_t mk(int v, int wis, int wb, int rd, int rs1, int rs2,
                                int rs3, int used, int ordy, int wbv, int wbw,
                                int wbr, int eop, int er, int eov, int est, int eerr);
        vec_t r;
        r.v = 1'(v);       r.wis = 2'(wis);   r.wb = 1'(wb);     r.rd = 6'(rd);
        r.rs1 = 6'(rs1);   r.rs2 = 6'(rs2);   r.rs3 = 6'(rs3);   r.used = 3'(used);
        r.ordy = 1'(ordy); r.wbv = 1'(wbv);   r.wbw = 2'(wbw);   r.wbr = 6'(wbr);
        r.eop = 1'(eop);   r.exp_rdy = 1'(er); r.exp_ov = 1'(eov);
        r.exp_st = est;    r.exp_err = 1'(eerr);
        return r;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic pkt_t cur_out();
        return {out_wis, out_rd, out_rs1, out_rs2, out_rs3, out_wb, out_data};
    endfunction

    function automatic pkt_t cur_in();
        return {in_wis, in_rd, in_rs1, in_rs2, in_rs3, in_wb, in_data};
    endfunction

    // Called once per cycle after inputs settle: hold-stability check,
    // scoreboard pop on handover, scoreboard push on acceptance.
    task automatic sample();
        pkt_t exp_p;
        if (reset) begin
            sb_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("out_hold", 192'(cur_out()), 192'(prev_pkt));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty: out_valid with nothing expected, rd=%0d", out_rd);
                end else begin
                    exp_p = sb_q.pop_front();
                    chk("sb_out", 192'(cur_out()), 192'(exp_p));
                    $display("txn out: wis=%0d rd=%0d rs1=%0d rs2=%0d rs3=%0d wb=%0d data=%0h",
                             out_wis, out_rd, out_rs1, out_rs2, out_rs3, out_wb, out_data[31:0]);
                end
            end
            if (in_valid && in_ready) sb_q.push_back(cur_in());
            prev_hold = out_valid && !out_ready;
            prev_pkt  = cur_out();
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input int idx);
        in_valid   = v.v;
        in_wis     = v.wis;
        in_wb      = v.wb;
        in_rd      = v.rd;
        in_rs1     = v.rs1;
        in_rs2     = v.rs2;
        in_rs3     = v.rs3;
        in_used_rs = v.used;
        in_data    = {4{32'hD00D_0000 + 32'(idx)}};
        out_ready  = v.ordy;
        wb_valid   = v.wbv;
        wb_wis     = v.wbw;
        wb_rd      = v.wbr;
        wb_eop     = v.eop;
    endtask

    initial begin
        int waited;
        n_cmp     = 0;
        n_err     = 0;
        prev_hold = 1'b0;
        prev_pkt  = '0;

        //            v wis wb rd rs1 rs2 rs3 used ordy wbv wbw wbr eop | rdy ov st err
        vecs[0]  = mk(1, 0, 1, 5,  0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 1, 6,  7, 0, 0, 1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0,  0, 5, 0, 2, 1, 0, 0, 0,  0, 0, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0,  0, 5, 0, 2, 1, 1, 0, 5,  1, 0, 0, 1, 0);
        vecs[4]  = mk(1, 0, 0, 0,  0, 5, 0, 2, 1, 0, 0, 0,  0, 1, 0, 2, 0);
        vecs[5]  = mk(1, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 2, 0);
        vecs[6]  = mk(1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0,  0, 1, 1, 2, 0);
        vecs[7]  = mk(1, 0, 0, 0,  1, 2, 6, 3, 1, 0, 0, 0,  0, 1, 1, 2, 0);
        vecs[8]  = mk(1, 0, 1, 0,  0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 1, 2, 0);
        vecs[9]  = mk(1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0);
        vecs[10] = mk(1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0);
        vecs[11] = mk(1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0);
        vecs[12] = mk(1, 1, 1, 10, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 2, 0);
        vecs[13] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 2, 0);
        vecs[14] = mk(1, 3, 1, 12, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 2, 0);
        vecs[15] = mk(1, 3, 0, 0, 12, 0, 0, 1, 1, 1, 3, 12, 0, 0, 1, 2, 0);
        vecs[16] = mk(1, 3, 0, 0, 12, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 3, 0);
        vecs[17] = mk(1, 0, 0, 0, 12, 0, 0, 1, 1, 0, 0, 0,  0, 1, 0, 4, 0);
        vecs[18] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 3, 9,  1, 1, 1, 4, 0);
        vecs[19] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 3, 12, 1, 1, 0, 4, 1);
        vecs[20] = mk(1, 3, 0, 0, 12, 0, 0, 1, 1, 0, 0, 0,  0, 1, 0, 4, 1);
        vecs[21] = mk(1, 2, 1, 8,  0, 0, 0, 0, 1, 1, 2, 8,  1, 1, 1, 4, 1);
        vecs[22] = mk(1, 2, 0, 0,  8, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 4, 1);
        vecs[23] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 5, 1);

        // Reset with a harmless instruction and a writeback pending.
        reset = 1'b1;
        drive(mk(1, 0, 1, 3, 0, 0, 0, 0, 1, 1, 1, 4, 1, 0, 0, 0, 0), 99);
        clk_edge();
        chk("rst.in_ready",    192'(in_ready),    192'(0));
        chk("rst.out_valid",   192'(out_valid),   192'(0));
        chk("rst.out_data",    192'(out_data),    192'(0));
        chk("rst.perf_stalls", 192'(perf_stalls), 192'(0));
        chk("rst.err_release", 192'(err_release), 192'(0));
        sample();
        clk_edge();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i], i);
            #1;
            chk($sformatf("v%0d.in_ready", i),    192'(in_ready),    192'(vecs[i].exp_rdy));
            chk($sformatf("v%0d.out_valid", i),   192'(out_valid),   192'(vecs[i].exp_ov));
            chk($sformatf("v%0d.perf_stalls", i), 192'(perf_stalls), 192'(vecs[i].exp_st));
            chk($sformatf("v%0d.err_release", i), 192'(err_release), 192'(vecs[i].exp_err));
            sample();
            clk_edge();
        end

        // Mid-operation reset: instruction held in the output register is
        // discarded and its destination never released.
        drive(mk(1, 1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
        #1;
        chk("h0.in_ready", 192'(in_ready), 192'(1));
        sample();
        clk_edge();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 101);
        #1;
        chk("h1.out_valid", 192'(out_valid), 192'(1));
        chk("h1.out_rd",    192'(out_rd),    192'(20));
        sample();
        clk_edge();
        reset = 1'b1;
        drive(mk(1, 1, 0, 0, 20, 0, 0, 1, 0, 1, 1, 20, 1, 0, 0, 0, 0), 102);
        #1;
        sample();
        clk_edge();
        chk("h2.in_ready",    192'(in_ready),    192'(0));
        chk("h2.out_valid",   192'(out_valid),   192'(0));
        chk("h2.out_data",    192'(out_data),    192'(0));
        chk("h2.perf_stalls", 192'(perf_stalls), 192'(0));
        chk("h2.err_release", 192'(err_release), 192'(0));
        reset = 1'b0;
        drive(mk(1, 1, 0, 0, 20, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 103);
        #1;
        chk("h3.in_ready",  192'(in_ready),  192'(1));
        chk("h3.out_valid", 192'(out_valid), 192'(0));
        chk("h3.out_rd",    192'(out_rd),    192'(0));
        sample();
        clk_edge();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 104);

        // Bounded wait for the post-reset instruction to appear.
        waited = 0;
        #1;
        while (!out_valid && waited < 8) begin
            sample();
            clk_edge();
            waited++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL h4.timeout: out_valid still %0b after %0d cycles, expected 1", out_valid, waited);
        end else begin
            chk("h4.latency", 192'(waited), 192'(0));
            chk("h4.out_rs1", 192'(out_rs1), 192'(20));
        end
        sample();
        clk_edge();
        #1;
        sample();
        chk("sb.drained", 192'(sb_q.size()), 192'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_issue_scoreboard.md
VX_ISSUE_SCOREBOARD -- requirements
Module: VX_issue_scoreboard

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: warps tracked per issue slot; WIS_W = clog2 of NUM_WARPS, minimum 1.
REQ-002 SHALL have parameter NUM_REGS, default 64: registers per warp; NR_BITS = clog2 of NUM_REGS.
REQ-003 SHALL have parameter DATAW, default 128: width of the opaque instruction payload.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream ibuffer handshake.
REQ-007 SHALL have port in_wis, input, WIS_W: warp index of the instruction.
REQ-008 SHALL have ports in_wb (input, 1) and in_rd (input, NR_BITS): destination-write flag and destination register.
REQ-009 SHALL have ports in_rs1, in_rs2, in_rs3, each input, NR_BITS: source registers.
REQ-010 SHALL have port in_used_rs, input, 3 bits: bit k set means source rs(k+1) is read.
REQ-011 SHALL have port in_data, input, DATAW: payload, passed through unmodified.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream operand-stage handshake.
REQ-013 SHALL have ports out_wis, out_rd, out_rs1, out_rs2, out_rs3, out_wb and out_data: registered copies of the corresponding inputs.
REQ-014 SHALL have ports wb_valid (input, 1), wb_wis (input, WIS_W), wb_rd (input, NR_BITS) and wb_eop (input, 1): writeback release.
REQ-015 SHALL have port perf_stalls, output, 32 bits: hazard-stall cycle counter.
REQ-016 SHALL have port err_release, output, 1 bit: sticky flag, set on release of a register that is not in use.

Function
REQ-017 SHALL keep an in-use bitmap of NUM_WARPS x NUM_REGS bits.
REQ-018 SHALL make hazard true when in_valid is high and in-use[in_wis] has a set bit at any of: rs1, rs2 or rs3 whose in_used_rs bit is set; or rd when in_wb is set (WAW).
REQ-019 SHALL treat register 0 as never in use: it is never set and never causes a hazard.
REQ-020 SHALL evaluate hazard from the registered bitmap only; a release is visible to the hazard check one cycle after wb_valid, with no same-cycle bypass.
REQ-021 SHALL drive in_ready = ~hazard AND (~out_valid OR out_ready).
REQ-022 SHALL define fire = in_valid AND in_ready; on fire, the output register loads all in_* fields and out_valid goes high on the next cycle (latency 1).
REQ-023 SHALL clear out_valid when out_ready is high and no fire occurs; out_* fields SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 SHALL set in-use[in_wis][in_rd] on the cycle after fire, when in_wb is set and in_rd is not 0.
REQ-025 SHALL clear in-use[wb_wis][wb_rd] on the cycle after wb_valid AND wb_eop; wb_valid with wb_eop low SHALL leave the bitmap unchanged.
REQ-026 SHALL let the set win when a set and a clear target the same bit in one cycle.
REQ-027 SHALL set err_release when a clear targets a bit that is already 0 and wb_rd is not 0; err_release stays high until reset.
REQ-028 SHALL increment perf_stalls by 1 in each cycle with in_valid AND hazard; the counter wraps modulo 2^32.
REQ-029 SHALL NOT let hazard for one warp block issue for a different warp presented on the next cycle.

Reset
REQ-030 SHALL, during reset, clear the bitmap and force out_valid=0, out_* data=0, perf_stalls=0 and err_release=0.
REQ-031 SHALL hold in_ready=0 while reset is high; a wb_valid during reset is ignored.
REQ-032 SHALL discard an instruction held in the output register when reset is asserted mid-operation, with no release required.

Verification
REQ-033 SHALL cover back-to-back independent issue: warp 0 issues rd=5, then rd=6 with rs1=7, out_ready=1 -> in_ready=1 every cycle, out_valid on cycles 1 and 2, bits 5 and 6 set.
REQ-034 SHALL cover RAW stall: issue rd=5; next instruction has rs2=5 with used_rs=3'b010 -> stall, perf_stalls counts; wb_valid, wb_eop, rd=5 at cycle N -> fire at cycle N+1, not N.
REQ-035 SHALL cover register 0 and unused sources: rd=0 with wb=1, then rs1=0; and rs3=5 in use with used_rs[2]=0 -> no stall, bitmap unchanged for x0.
REQ-036 SHALL cover backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_* stable; out_ready=1 -> drains, then accepts the next instruction.
REQ-037 SHALL cover partial and erroneous release: wb_eop=0 -> bit stays set; release of clear reg 9 -> err_release=1 and sticky; reset -> err_release=0, bitmap empty.
REQ-038 SHALL cover same-cycle set and clear of reg 8 in warp 2 -> bit 8 remains set next cycle.
